// File: rtl/hdlc_inputregister.sv
// ============================================================================
// Module      : hdlc_inputregister
// Description : HDLC receive deserializer. It hunts for flags, removes stuffed
//               zeros, detects aborts and assembles words plus frame delimiters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hdlc_inputregister #(
    parameter int WORD_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              serin,
    input  logic              bit_en,
    output logic [WORD_W-1:0] data_out,
    output logic              data_valid,
    output logic              data_first,
    output logic              frame_end,
    output logic              frame_error,
    output logic              abort,
    output logic [CNT_W-1:0]  frame_words,
    output logic              in_frame
);

    localparam int                IDX_W    = $clog2(WORD_W);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [2:0]        DL_FULL  = 3'd6;

    localparam logic [0:0] ST_HUNT  = 1'b0;
    localparam logic [0:0] ST_FRAME = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [2:0]        ones_q, ones_d;
    logic [5:0]        dl_q, dl_d;
    logic [2:0]        dl_cnt_q, dl_cnt_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              first_q, first_d;

    logic [WORD_W-1:0] data_out_q, data_out_d;
    logic              data_valid_q, data_valid_d;
    logic              data_first_q, data_first_d;
    logic              frame_end_q, frame_end_d;
    logic              frame_error_q, frame_error_d;
    logic              abort_q, abort_d;
    logic [CNT_W-1:0]  frame_words_q, frame_words_d;

    logic ev_data, ev_bit, ev_flag, ev_abort;
    logic pop, pop_bit;

    // Line bit classification from the running count of consecutive ones
    always_comb begin
        ev_data  = 1'b0;
        ev_bit   = 1'b0;
        ev_flag  = 1'b0;
        ev_abort = 1'b0;
        ones_d   = ones_q;
        if (bit_en) begin
            if (serin) begin
                if (ones_q < 3'd5) begin
                    ev_data = 1'b1;
                    ev_bit  = 1'b1;
                    ones_d  = ones_q + 3'd1;
                end else if (ones_q == 3'd5) begin
                    ones_d = 3'd6;
                end else begin
                    ev_abort = 1'b1;
                    ones_d   = 3'd7;
                end
            end else begin
                ones_d = 3'd0;
                if (ones_q == 3'd6) begin
                    ev_flag = 1'b1;
                end else if (ones_q != 3'd5) begin
                    ev_data = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (ev_flag) begin
            state_d = ST_FRAME;
        end else if (ev_abort) begin
            state_d = ST_HUNT;
        end
    end

    always_comb begin
        dl_d          = dl_q;
        dl_cnt_d      = dl_cnt_q;
        pop           = 1'b0;
        pop_bit       = dl_q[0];
        word_d        = word_q;
        idx_d         = idx_q;
        count_d       = count_q;
        first_d       = first_q;
        data_out_d    = data_out_q;
        data_valid_d  = 1'b0;
        data_first_d  = 1'b0;
        frame_end_d   = 1'b0;
        frame_error_d = 1'b0;
        abort_d       = 1'b0;
        frame_words_d = frame_words_q;

        // The six-bit delay line holds back the leading 0 and five 1s of a
        // potential flag so they never reach the assembler.
        if (ev_flag || ev_abort) begin
            dl_d     = '0;
            dl_cnt_d = 3'd0;
        end else if (ev_data) begin
            if (dl_cnt_q == DL_FULL) begin
                pop  = 1'b1;
                dl_d = {ev_bit, dl_q[5:1]};
            end else begin
                dl_d[dl_cnt_q] = ev_bit;
                dl_cnt_d       = dl_cnt_q + 3'd1;
            end
        end

        if (ev_flag) begin
            if (state_q == ST_FRAME) begin
                if (idx_q != '0) begin
                    frame_error_d = 1'b1;
                    frame_words_d = count_q;
                end else if (count_q != '0) begin
                    frame_end_d   = 1'b1;
                    frame_words_d = count_q;
                end
            end
            word_d  = '0;
            idx_d   = '0;
            count_d = '0;
            first_d = 1'b1;
        end else if (ev_abort) begin
            abort_d = (state_q == ST_FRAME);
        end else if (pop && state_q == ST_FRAME) begin
            word_d[idx_q] = pop_bit;
            if (idx_q == IDX_LAST) begin
                data_out_d   = word_d;
                data_valid_d = 1'b1;
                data_first_d = first_q;
                first_d      = 1'b0;
                idx_d        = '0;
                count_d      = (count_q == CNT_MAX) ? count_q : count_q + 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ones_q        <= '0;
            dl_q          <= '0;
            dl_cnt_q      <= '0;
            word_q        <= '0;
            idx_q         <= '0;
            count_q       <= '0;
            first_q       <= 1'b0;
            data_out_q    <= '0;
            data_valid_q  <= 1'b0;
            data_first_q  <= 1'b0;
            frame_end_q   <= 1'b0;
            frame_error_q <= 1'b0;
            abort_q       <= 1'b0;
            frame_words_q <= '0;
        end else begin
            ones_q        <= ones_d;
            dl_q          <= dl_d;
            dl_cnt_q      <= dl_cnt_d;
            word_q        <= word_d;
            idx_q         <= idx_d;
            count_q       <= count_d;
            first_q       <= first_d;
            data_out_q    <= data_out_d;
            data_valid_q  <= data_valid_d;
            data_first_q  <= data_first_d;
            frame_end_q   <= frame_end_d;
            frame_error_q <= frame_error_d;
            abort_q       <= abort_d;
            frame_words_q <= frame_words_d;
        end
    end

    assign data_out    = data_out_q;
    assign data_valid  = data_valid_q;
    assign data_first  = data_first_q;
    assign frame_end   = frame_end_q;
    assign frame_error = frame_error_q;
    assign abort       = abort_q;
    assign frame_words = frame_words_q;
    assign in_frame    = (state_q == ST_FRAME);

endmodule

`default_nettype wire

// File: tb/tb_hdlc_inputregister.sv
// ============================================================================
// Module      : tb_hdlc_inputregister
// Description : Scoreboard bench: frames are built as destuffed payloads, the
//               expected events are queued and a monitor compares DUT pulses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_hdlc_inputregister;

    localparam int WORD_W = 16;
    localparam int CNT_W  = 8;
    localparam int K_DATA = 0, K_END = 1, K_ERR = 2, K_ABORT = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              serin = 1'b0;
    logic              bit_en = 1'b0;
    logic [WORD_W-1:0] data_out;
    logic              data_valid, data_first, frame_end, frame_error, abort;
    logic [CNT_W-1:0]  frame_words;
    logic              in_frame;

    hdlc_inputregister #(.WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .serin      (serin),
        .bit_en     (bit_en),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_first (data_first),
        .frame_end  (frame_end),
        .frame_error(frame_error),
        .abort      (abort),
        .frame_words(frame_words),
        .in_frame   (in_frame)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                kind;
        logic [WORD_W-1:0] data;
        logic              first;
        logic [CNT_W-1:0]  words;
    } ev_t;

    ev_t exp_q[$];
    bit  payload[$];
    int  checks   = 0;
    int  failures = 0;
    bit  gaps_on  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_raw(input bit b);
        if (gaps_on) begin
            int g;
            g = $urandom_range(0, 2);
            repeat (g) begin
                @(negedge clk);
                bit_en = 1'b0;
                serin  = 1'($urandom_range(0, 1));
            end
        end
        @(negedge clk);
        bit_en = 1'b1;
        serin  = b;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bit_en = 1'b0;
            serin  = 1'b0;
        end
    endtask

    task automatic send_flag();
        send_raw(1'b0);
        repeat (6) send_raw(1'b1);
        send_raw(1'b0);
    endtask

    // Transmitter-side zero insertion after five consecutive ones
    task automatic send_stuffed();
        int run;
        run = 0;
        foreach (payload[i]) begin
            send_raw(payload[i]);
            if (payload[i]) begin
                run++;
                if (run == 5) begin
                    send_raw(1'b0);
                    run = 0;
                end
            end else begin
                run = 0;
            end
        end
    endtask

    task automatic add_word(input logic [WORD_W-1:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) payload.push_back(w[i]);
    endtask

    task automatic add_random(input int nbits);
        for (int i = 0; i < nbits; i++) payload.push_back($urandom_range(0, 3) != 0);
    endtask

    // A closing flag releases every payload bit; an abort releases only the
    // bits pushed more than six places ahead of its first non-data one.
    task automatic queue_events(input bit by_abort);
        int n, k, released, nw;
        n = payload.size();
        k = 0;
        if (by_abort) begin
            for (int i = n - 1; i >= 0 && payload[i]; i--) k++;
            released = n + (5 - k % 5) - 6;
            if (released < 0) released = 0;
        end else begin
            released = n;
        end
        nw = released / WORD_W;
        for (int w = 0; w < nw; w++) begin
            ev_t e;
            e.kind  = K_DATA;
            e.first = (w == 0);
            e.words = '0;
            for (int b = 0; b < WORD_W; b++) e.data[b] = payload[w * WORD_W + b];
            exp_q.push_back(e);
        end
        if (by_abort || n % WORD_W != 0 || nw > 0) begin
            ev_t e;
            e.kind  = by_abort ? K_ABORT : ((n % WORD_W != 0) ? K_ERR : K_END);
            e.data  = '0;
            e.first = 1'b0;
            e.words = (nw > 255) ? 8'd255 : CNT_W'(nw);
            exp_q.push_back(e);
        end
    endtask

    task automatic run_frame(input bit by_abort);
        queue_events(by_abort);
        send_stuffed();
        if (by_abort) begin
            int extra;
            extra = $urandom_range(0, 3);
            repeat (7 + extra) send_raw(1'b1);
        end else begin
            send_flag();
        end
        payload.delete();
    endtask

    initial begin : monitor
        forever begin
            int  kind;
            int  npulse;
            ev_t e;
            @(posedge clk);
            #1;
            if (data_valid || frame_end || frame_error || abort) begin
                npulse = int'(data_valid) + int'(frame_end) + int'(frame_error) + int'(abort);
                kind = data_valid ? K_DATA : frame_end ? K_END : frame_error ? K_ERR : K_ABORT;
                check("single_pulse", npulse, 1);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_event: got kind %0d expected none", kind);
                end else begin
                    e = exp_q.pop_front();
                    check("event_kind", kind, e.kind);
                    if (e.kind == K_DATA) begin
                        check("data_out", data_out, e.data);
                        check("data_first", data_first, e.first);
                    end else if (e.kind != K_ABORT) begin
                        check("frame_words", frame_words, e.words);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int wait_cnt;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data_out", data_out, 0);
        check("rst_data_valid", data_valid, 0);
        check("rst_data_first", data_first, 0);
        check("rst_frame_end", frame_end, 0);
        check("rst_frame_error", frame_error, 0);
        check("rst_abort", abort, 0);
        check("rst_frame_words", frame_words, 0);
        check("rst_in_frame", in_frame, 0);
        reset = 1'b0;

        // Idle flags open a frame but produce no events
        send_flag();
        idle(1);
        check("t1_in_frame", in_frame, 1);
        repeat (3) send_flag();
        idle(2);
        check("t1_still_in_frame", in_frame, 1);

        add_word(16'h1234, 16);
        add_word(16'hABCD, 16);
        run_frame(1'b0);

        add_word(16'hFFFF, 16);
        run_frame(1'b0);

        add_word(16'h005A, 8);
        run_frame(1'b0);
        add_word(16'h0001, 16);
        run_frame(1'b0);

        add_word(16'h00F0, 16);
        queue_events(1'b1);
        send_stuffed();
        payload.delete();
        repeat (8) send_raw(1'b1);
        idle(2);
        check("t5_in_frame_after_abort", in_frame, 0);
        add_word(16'h1111, 16);
        send_stuffed();
        payload.delete();
        idle(2);
        check("t5_hunt_ignores_data", in_frame, 0);
        send_flag();
        idle(1);
        check("t5_reopen", in_frame, 1);

        // Reset mid-frame discards the partial word silently
        add_word(16'h8001, 8);
        send_stuffed();
        payload.delete();
        @(negedge clk);
        bit_en = 1'b0;
        reset  = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t6_in_frame_after_reset", in_frame, 0);
        send_flag();
        add_word(16'h8001, 16);
        run_frame(1'b0);

        gaps_on = 1'b1;
        for (int f = 0; f < 40; f++) begin
            int mode;
            mode = $urandom_range(0, 3);
            if (mode == 0) add_random(WORD_W * $urandom_range(1, 3));
            else add_random($urandom_range(0, 60));
            if (mode == 3) begin
                run_frame(1'b1);
                send_flag();
            end else begin
                run_frame(1'b0);
            end
            if ($urandom_range(0, 3) == 0) send_flag();
        end
        gaps_on = 1'b0;

        // Long frame drives the word counter into saturation
        add_random(WORD_W * 260);
        run_frame(1'b0);

        idle(4);
        wait_cnt = 0;
        while (exp_q.size() != 0 && wait_cnt < 200) begin
            idle(1);
            wait_cnt++;
        end
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
